fetch_stage: RTL and testbench
==============================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, PC loaded on reset.
REQ-002 SHALL have parameter NOP_INSTR, default 32'h0000_0013 (addi x0,x0,0), bubble instruction.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port stall_f  input  1  hold fetch PC (from hazard unit).
REQ-006 SHALL have port stall_d  input  1  hold fetch/decode register (from hazard unit).
REQ-007 SHALL have port flush_d  input  1  bubble fetch/decode register (from hazard unit).
REQ-008 SHALL have port pc_src_x  input  1  taken branch/jump resolved in execute.
REQ-009 SHALL have port pc_target_x  input  32  redirect target.
REQ-010 SHALL have ports imem_req output 1, imem_addr output 32, imem_ready input 1, imem_rdata input 32  instruction-memory handshake.
REQ-011 SHALL have ports instr_d output 32, pc_d output 32, pc_plus4_d output 32, valid_d output 1  fetch/decode register.
REQ-012 SHALL have port fetch_wait  output  1  high while FETCH request is not yet answered.

Function
REQ-013 SHALL hold a 32-bit pc_f and a 3-state FSM: FETCH, HOLD, DRAIN.
REQ-014 Handshake: transfer occurs on a cycle with imem_req=1 and imem_ready=1; imem_addr SHALL stay constant from request until transfer; at most one request outstanding.
REQ-015 FETCH: imem_req=1, imem_addr=pc_f; fetch_wait=!imem_ready.
REQ-016 FETCH, transfer, stall_f=0, stall_d=0, no redirect: load IF/ID with instr=imem_rdata, pc=pc_f, pc_plus4=pc_f+4, valid=1; pc_f<=pc_f+4; stay FETCH.
REQ-017 FETCH, transfer, stall_f or stall_d high, no redirect: capture rdata into hold buffer, IF/ID unchanged, pc_f unchanged, go HOLD.
REQ-018 FETCH, no transfer, stall_d=0, no redirect/flush: IF/ID loads bubble (NOP_INSTR, valid=0, pc fields unchanged); stall_d=1 holds IF/ID.
REQ-019 HOLD: imem_req=0; when stall_f=0 and stall_d=0, load IF/ID from hold buffer (valid=1), pc_f<=pc_f+4, go FETCH.
REQ-020 Redirect (pc_src_x=1) SHALL override stall_f/stall_d: pc_f<=pc_target_x, hold buffer discarded.
REQ-021 Redirect in FETCH with transfer same cycle, or in HOLD: go FETCH, response dropped.
REQ-022 Redirect in FETCH without transfer: go DRAIN; DRAIN keeps imem_req=1 with old address, discards data at transfer, then goes FETCH at pc_f; fetch_wait=0 in DRAIN.
REQ-023 Redirect in DRAIN: update pc_f only, remain DRAIN.
REQ-024 flush_d=1 SHALL load IF/ID bubble (NOP_INSTR, valid=0), overriding stall_d and any IF/ID load that cycle.
REQ-025 Priority: reset > pc_src_x > flush_d > stall_f/stall_d > normal.
REQ-026 Arithmetic: pc+4 modulo 2^32 (0xFFFF_FFFC wraps to 0); pc_target_x used unaltered, no alignment check.
REQ-027 Latency: zero-wait memory SHALL yield one instruction per cycle, IF/ID valid the cycle after transfer.

Reset
REQ-028 Reset SHALL immediately force: pc_f=RESET_PC, state FETCH, hold buffer empty, instr_d=NOP_INSTR, valid_d=0, pc_d=0, pc_plus4_d=0.
REQ-029 Reset asserted mid-handshake or in DRAIN SHALL abandon the outstanding request; first post-reset request addresses RESET_PC.

Verification
REQ-030 Reset release, imem_ready=1 always, rdata=addr-tagged -> instr_d sequence for pc_d 0,4,8,12 on consecutive cycles, valid_d=1.
REQ-031 stall_f=stall_d=1 for 3 cycles while transfer at pc 0x8 -> HOLD, imem_req=0, IF/ID unchanged; release -> instr at 0x8 appears once, next request 0xC.
REQ-032 imem_ready delayed 2 cycles at pc 0x10 -> fetch_wait=1 two cycles, valid_d=0 bubbles, then instr 0x10 valid.
REQ-033 pc_src_x=1, flush_d=1, pc_target_x=0x100 while request at 0x20 unanswered -> DRAIN, imem_addr stays 0x20, data discarded, next request 0x100, valid_d=0 meanwhile.
REQ-034 pc_src_x=1 and stall_d=1 same cycle in HOLD -> hold discarded, IF/ID bubble, next request pc_target_x.
REQ-035 reset pulse during DRAIN -> all outputs at reset values asynchronously, next request 0x0.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, single-outstanding imem handshake and IF/ID register.
// FETCH | request at pc_f, load IF/ID on transfer
// HOLD  | response captured while stalled, waiting to release into IF/ID
// DRAIN | redirect left a request open; wait for it and discard the data
module fetch_stage #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall_f,
   input  logic        stall_d,
   input  logic        flush_d,
   input  logic        pc_src_x,
   input  logic [31:0] pc_target_x,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic [31:0] imem_rdata,
   output logic [31:0] instr_d,
   output logic [31:0] pc_d,
   output logic [31:0] pc_plus4_d,
   output logic        valid_d,
   output logic        fetch_wait
);

   localparam logic [1:0] FETCH = 2'd0;
   localparam logic [1:0] HOLD  = 2'd1;
   localparam logic [1:0] DRAIN = 2'd2;

   logic [1:0]  state, state_nx;
   logic [31:0] pc_f, pc_f_nx;
   logic [31:0] pc_plus4_f;
   logic [31:0] drain_addr, drain_addr_nx;
   logic [31:0] hold_instr, hold_instr_nx;
   logic [31:0] ifid_instr;
   logic        ifid_load, ifid_bubble;
   logic        transfer, stall;

   assign pc_plus4_f = pc_f + 32'd4;
   assign imem_req   = (state == FETCH) || (state == DRAIN);
   // DRAIN must keep presenting the abandoned address until it is answered
   assign imem_addr  = (state == DRAIN) ? drain_addr : pc_f;
   assign fetch_wait = (state == FETCH) && !imem_ready;
   assign transfer   = imem_req && imem_ready;
   assign stall      = stall_f || stall_d;

   always_comb begin
      state_nx      = state;
      pc_f_nx       = pc_f;
      drain_addr_nx = drain_addr;
      hold_instr_nx = hold_instr;
      ifid_instr    = hold_instr;
      ifid_load     = 1'b0;
      ifid_bubble   = 1'b0;
      if (pc_src_x) begin
         pc_f_nx       = pc_target_x;
         hold_instr_nx = NOP_INSTR;
         ifid_bubble   = 1'b1;
         case (state)
            FETCH: begin
               if (!transfer) begin
                  state_nx      = DRAIN;
                  drain_addr_nx = pc_f;
               end
            end
            DRAIN:   state_nx = DRAIN;
            default: state_nx = FETCH;
         endcase
      end else begin
         case (state)
            FETCH: begin
               if (transfer) begin
                  if (stall) begin
                     hold_instr_nx = imem_rdata;
                     state_nx      = HOLD;
                  end else begin
                     ifid_load  = 1'b1;
                     ifid_instr = imem_rdata;
                     pc_f_nx    = pc_plus4_f;
                  end
               end else if (!stall_d) begin
                  ifid_bubble = 1'b1;
               end
            end
            HOLD: begin
               if (!stall) begin
                  ifid_load = 1'b1;
                  pc_f_nx   = pc_plus4_f;
                  state_nx  = FETCH;
               end
            end
            DRAIN: begin
               if (!stall_d) ifid_bubble = 1'b1;
               if (transfer) state_nx = FETCH;
            end
            default: state_nx = FETCH;
         endcase
         if (flush_d) begin
            ifid_bubble = 1'b1;
            ifid_load   = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= FETCH;
         pc_f       <= RESET_PC;
         drain_addr <= RESET_PC;
         hold_instr <= NOP_INSTR;
         instr_d    <= NOP_INSTR;
         pc_d       <= 32'd0;
         pc_plus4_d <= 32'd0;
         valid_d    <= 1'b0;
      end else begin
         state      <= state_nx;
         pc_f       <= pc_f_nx;
         drain_addr <= drain_addr_nx;
         hold_instr <= hold_instr_nx;
         if (ifid_bubble) begin
            instr_d <= NOP_INSTR;
            valid_d <= 1'b0;
         end else if (ifid_load) begin
            instr_d    <= ifid_instr;
            pc_d       <= pc_f;
            pc_plus4_d <= pc_plus4_f;
            valid_d    <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: per-cycle expected IF/ID contents queued and compared each edge.
module tb_fetch_stage;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk, reset;
   logic        stall_f, stall_d, flush_d, pc_src_x;
   logic [31:0] pc_target_x;
   logic        imem_req, imem_ready;
   logic [31:0] imem_addr, imem_rdata;
   logic [31:0] instr_d, pc_d, pc_plus4_d;
   logic        valid_d, fetch_wait;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic        v;
      logic [31:0] instr;
      logic [31:0] pc;
      logic [31:0] pc4;
   } exp_t;
   exp_t exp_q[$];

   function automatic logic [31:0] tag(input logic [31:0] a);
      return {8'hA5, a[23:0]};
   endfunction

   assign imem_rdata = tag(imem_addr);

   fetch_stage dut (
      .clk(clk), .reset(reset), .stall_f(stall_f), .stall_d(stall_d),
      .flush_d(flush_d), .pc_src_x(pc_src_x), .pc_target_x(pc_target_x),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
      .imem_rdata(imem_rdata), .instr_d(instr_d), .pc_d(pc_d),
      .pc_plus4_d(pc_plus4_d), .valid_d(valid_d), .fetch_wait(fetch_wait)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", name, obs, expv);
      end
   endtask

   // combinational request-side outputs, sampled mid-cycle after inputs settle
   task automatic pre(input logic [31:0] addr, input logic req, input logic fw);
      #1;
      chk("imem_req", {31'd0, imem_req}, {31'd0, req});
      if (req) chk("imem_addr", imem_addr, addr);
      chk("fetch_wait", {31'd0, fetch_wait}, {31'd0, fw});
   endtask

   task automatic push(input logic v, input logic [31:0] pc);
      exp_t e;
      e.v     = v;
      e.instr = v ? tag(pc) : NOP;
      e.pc    = pc;
      e.pc4   = pc + 32'd4;
      exp_q.push_back(e);
   endtask

   task automatic cyc();
      exp_t e;
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
         checks++;
         errors++;
         $error("FAIL sb_underflow: observed empty queue expected entry");
      end else begin
         e = exp_q.pop_front();
         chk("valid_d", {31'd0, valid_d}, {31'd0, e.v});
         chk("instr_d", instr_d, e.instr);
         if (e.v) begin
            chk("pc_d", pc_d, e.pc);
            chk("pc_plus4_d", pc_plus4_d, e.pc4);
         end
      end
   endtask

   initial begin
      reset = 1'b1; stall_f = 0; stall_d = 0; flush_d = 0; pc_src_x = 0;
      pc_target_x = 32'd0; imem_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_instr", instr_d, NOP);
      chk("rst_valid", {31'd0, valid_d}, 32'd0);
      chk("rst_pc_d", pc_d, 32'd0);
      chk("rst_pc4_d", pc_plus4_d, 32'd0);
      reset = 1'b0;

      // zero-wait streaming
      pre(32'h0, 1, 0); push(1, 32'h0); cyc();
      pre(32'h4, 1, 0); push(1, 32'h4); cyc();
      // stall during transfer at 0x8 -> HOLD for three cycles
      stall_f = 1; stall_d = 1;
      pre(32'h8, 1, 0); push(1, 32'h4); cyc();
      pre(32'h0, 0, 0); push(1, 32'h4); cyc();
      pre(32'h0, 0, 0); push(1, 32'h4); cyc();
      stall_f = 0; stall_d = 0;
      pre(32'h0, 0, 0); push(1, 32'h8); cyc();
      pre(32'hC, 1, 0); push(1, 32'hC); cyc();
      // two wait cycles at 0x10
      imem_ready = 0;
      pre(32'h10, 1, 1); push(0, 32'h0); cyc();
      pre(32'h10, 1, 1); push(0, 32'h0); cyc();
      imem_ready = 1;
      pre(32'h10, 1, 0); push(1, 32'h10); cyc();
      pre(32'h14, 1, 0); push(1, 32'h14); cyc();
      pre(32'h18, 1, 0); push(1, 32'h18); cyc();
      pre(32'h1C, 1, 0); push(1, 32'h1C); cyc();
      // redirect with open request at 0x20 -> DRAIN
      imem_ready = 0; pc_src_x = 1; flush_d = 1; pc_target_x = 32'h100;
      pre(32'h20, 1, 1); push(0, 32'h0); cyc();
      pc_src_x = 0; flush_d = 0;
      pre(32'h20, 1, 0); push(0, 32'h0); cyc();
      imem_ready = 1;
      pre(32'h20, 1, 0); push(0, 32'h0); cyc();
      pre(32'h100, 1, 0); push(1, 32'h100); cyc();
      // redirect with stall_d while in HOLD
      stall_f = 1; stall_d = 1;
      pre(32'h104, 1, 0); push(1, 32'h100); cyc();
      stall_f = 0; pc_src_x = 1; pc_target_x = 32'h200;
      pre(32'h0, 0, 0); push(0, 32'h0); cyc();
      stall_d = 0; pc_src_x = 0;
      pre(32'h200, 1, 0); push(1, 32'h200); cyc();
      // redirect with same-cycle transfer to top of address space, then wrap
      pc_src_x = 1; pc_target_x = 32'hFFFF_FFFC;
      pre(32'h204, 1, 0); push(0, 32'h0); cyc();
      pc_src_x = 0;
      pre(32'hFFFF_FFFC, 1, 0); push(1, 32'hFFFF_FFFC); cyc();
      pre(32'h0, 1, 0); push(1, 32'h0); cyc();
      // flush alone still advances pc_f
      flush_d = 1;
      pre(32'h4, 1, 0); push(0, 32'h0); cyc();
      flush_d = 0;
      pre(32'h8, 1, 0); push(1, 32'h8); cyc();
      // reset pulse while draining
      imem_ready = 0; pc_src_x = 1; pc_target_x = 32'h300;
      pre(32'hC, 1, 1); push(0, 32'h0); cyc();
      pc_src_x = 0;
      pre(32'hC, 1, 0);
      reset = 1'b1;
      #1;
      chk("arst_instr", instr_d, NOP);
      chk("arst_valid", {31'd0, valid_d}, 32'd0);
      chk("arst_pc_d", pc_d, 32'd0);
      chk("arst_pc4_d", pc_plus4_d, 32'd0);
      chk("arst_addr", imem_addr, 32'h0);
      chk("arst_fetch_wait", {31'd0, fetch_wait}, 32'd1);
      @(posedge clk);
      #1;
      reset = 1'b0;
      imem_ready = 1;
      pre(32'h0, 1, 0); push(1, 32'h0); cyc();
      pre(32'h4, 1, 0); push(1, 32'h4); cyc();

      chk("sb_leftover", exp_q.size(), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
